fft_ctrl: RTL and testbench
===========================

# fft_ctrl

Scheduler and data buffer for the 16-point radix-2 DIF FFT that feeds the butterfly PE.
- Collects 16 packed complex samples and runs 4 stages × 8 butterflies, one at a time, through the PE's ab_valid/fft_pe_valid handshake.
- Writes each butterfly result back in place.
- Streams the 16 results out in natural frequency order by reading in bit-reversed order.
- Sits between the sample source and the output consumer; the PE is external.

## Interface
- No parameters; N=16, stages=4 and 16-bit real/imag fields are fixed.
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  input sample strobe
- din  in  32  sample: real [31:16], imag [15:0], signed Q8.8
- busy  out  1  high from the 16th accepted sample until done
- pe_a  out  32  butterfly top operand to PE
- pe_b  out  32  butterfly bottom operand to PE
- pe_power  out  3  twiddle index k (W16^k) to PE
- pe_ab_valid  out  1  one-cycle issue strobe to PE
- pe_fft_a  in  32  PE result a+b
- pe_fft_b  in  32  PE result (a−b)·W
- pe_fft_valid  in  1  PE result strobe
- dout_valid  out  1  output sample strobe
- dout  out  32  output bin, same packing as din
- done  out  1  one-cycle pulse with the last output bin

## Operation
- Storage: 16×32 register file mem[0..15]. The block only stores and moves words; it does no arithmetic on data.
- States: IDLE, LOAD, ISSUE, WAIT, GAP, OUT.
  - IDLE→LOAD on the first din_valid.
- LOAD:
  - Each din_valid=1 cycle writes mem[wcnt] and increments wcnt. Gaps between samples are allowed.
  - After the 16th write, go to ISSUE with stage s=0 and butterfly n=0.
- Butterfly addressing, with span=8>>s:
  - j = n & (span−1)
  - i = ((n >> (3−s)) << (4−s)) | j
  - Operand pair is mem[i] and mem[i+span]; power = j << s.
- ISSUE (1 cycle):
  - Drive pe_a=mem[i], pe_b=mem[i+span], pe_power, pe_ab_valid=1.
  - Go to WAIT.
- WAIT: on pe_fft_valid=1, write mem[i]←pe_fft_a and mem[i+span]←pe_fft_b, then go to GAP.
- GAP:
  - Stay until pe_fft_valid=0. This prevents double capture of a PE valid that is high for more than one posedge.
  - Then advance n. When n wraps 7→0, increment s.
  - After s=3, n=7: go to OUT with k=0. Otherwise go to ISSUE.
- OUT:
  - 16 consecutive cycles with dout_valid=1 and dout=mem[bitrev4(k)], for k=0..15.
  - done=1 together with k=15, then go to IDLE.
- din_valid outside IDLE/LOAD is ignored; no samples are lost inside LOAD.
- pe_fft_valid outside WAIT/GAP is ignored.

## Timing
- Reset values: busy=0, pe_a=0, pe_b=0, pe_power=0, pe_ab_valid=0, dout_valid=0, dout=0, done=0. State is IDLE, all counters are 0, mem is don't-care.
- All outputs are registered.
  - pe_a, pe_b and pe_power hold from the issue cycle until the next issue.
  - dout holds its last value when dout_valid=0.
- Per butterfly: 1 ISSUE cycle + WAIT (PE latency) + at least 1 GAP cycle.
  - With a PE whose valid is high at exactly the 2nd posedge after the issue edge, each butterfly takes 4 cycles and all 32 take 128 cycles.
- busy rises the cycle after the 16th din_valid and falls the cycle after done.
- The first dout_valid comes 1 cycle after the final GAP exit.
- rst asserted mid-operation, in any state, immediately returns to reset values. A partially loaded frame is discarded.
- Results wrap exactly as the PE produces them; no saturation is performed in this block.

## Test plan
- Issue order: load x[m]=m<<16, with a fixed-latency PE model.
  - Required first three issues: (pe_a,pe_b,pe_power) = (x0,x8,0), (x1,x9,1), (x2,x10,2).
  - Required first issue of stage 1: operands mem[0], mem[4] with power 0, then mem[1], mem[5] with power 2.
  - Required first issue of stage 3: operands mem[0], mem[1] with power 0.
- Impulse: x0=0x01000000, all other samples 0, with a bit-accurate PE model → all 16 dout = 0x01000000, done on the 16th.
- DC: all samples 0x01000000 → dout[0]=0x10000000, the other 15 outputs 0, bins in natural order.
- Gapped input and stretched PE valid:
  - din_valid toggles every other cycle.
  - The PE holds valid for 3 cycles.
  - Required response: result identical to the DC case and exactly 32 pe_ab_valid pulses.
- Reset mid-frame: assert rst after 20 butterflies → all outputs 0 the same cycle. A fresh impulse frame then gives the correct impulse result.
- Ignore rules: din_valid pulses while busy=1 and spurious pe_fft_valid in IDLE leave mem and the output sequence unchanged.

Source files
------------

// File: rtl/fft_ctrl_if.sv
// Bus bundle between fft_ctrl and its sample source, butterfly PE and output consumer.
interface fft_ctrl_if;
    logic        din_valid;
    logic [31:0] din;
    logic        busy;
    logic [31:0] pe_a;
    logic [31:0] pe_b;
    logic [2:0]  pe_power;
    logic        pe_ab_valid;
    logic [31:0] pe_fft_a;
    logic [31:0] pe_fft_b;
    logic        pe_fft_valid;
    logic        dout_valid;
    logic [31:0] dout;
    logic        done;

    // controller side
    modport master (
        input  din_valid, din, pe_fft_a, pe_fft_b, pe_fft_valid,
        output busy, pe_a, pe_b, pe_power, pe_ab_valid, dout_valid, dout, done
    );

    // environment side: sample source, PE and output consumer
    modport slave (
        output din_valid, din, pe_fft_a, pe_fft_b, pe_fft_valid,
        input  busy, pe_a, pe_b, pe_power, pe_ab_valid, dout_valid, dout, done
    );
endinterface

// File: rtl/fft_ctrl.sv
// fft_ctrl: sample buffer and butterfly scheduler for a 16-point radix-2 DIF FFT.
// The butterfly PE is external; this block only addresses, stores and moves words.
//
// state | meaning
// IDLE  | waiting for the first sample of a frame (that sample is stored)
// LOAD  | collecting the remaining samples into mem[wcnt]
// ISSUE | presenting one butterfly's operands to the PE
// WAIT  | waiting for the PE result, written back in place
// GAP   | waiting for PE valid to drop before advancing to the next butterfly
// OUT   | streaming mem in bit-reversed address order (natural bin order)
module fft_ctrl (
    input logic       clk,
    input logic       rst,
    fft_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_OUT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] mem [16];
    logic [3:0]  wcnt;
    logic [1:0]  stage;
    logic [2:0]  bfly;
    logic [3:0]  kcnt;

    logic [3:0]  span;
    logic [3:0]  j_idx;
    logic [3:0]  i_top;
    logic [3:0]  i_bot;
    logic [2:0]  power;
    logic [3:0]  k_rev;
    logic        take_sample;
    logic        frame_full;
    logic        gap_exit;
    logic        last_bfly;
    logic        wr_back;

    // Butterfly operand addresses and twiddle index from (stage, butterfly)
    always_comb begin
        span  = 4'd8 >> stage;
        j_idx = {1'b0, bfly} & (span - 4'd1);
        i_top = (({1'b0, bfly} >> (2'd3 - stage)) << (3'd4 - {1'b0, stage})) | j_idx;
        i_bot = i_top + span;
        power = j_idx[2:0] << stage;
        k_rev = {kcnt[0], kcnt[1], kcnt[2], kcnt[3]};
    end

    // Qualified events shared by the FSM and the datapath
    always_comb begin
        take_sample = bus.din_valid && ((state == S_IDLE) || (state == S_LOAD));
        frame_full  = take_sample && (state == S_LOAD) && (wcnt == 4'd15);
        gap_exit    = (state == S_GAP) && !bus.pe_fft_valid;
        last_bfly   = (stage == 2'd3) && (bfly == 3'd7);
        wr_back     = (state == S_WAIT) && bus.pe_fft_valid;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.din_valid) state_nxt = S_LOAD;
            S_LOAD:  if (frame_full) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (bus.pe_fft_valid) state_nxt = S_GAP;
            S_GAP:   if (gap_exit) state_nxt = last_bfly ? S_OUT : S_ISSUE;
            S_OUT:   if (kcnt == 4'd15) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sample storage and in-place write-back; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (take_sample) begin
            mem[wcnt] <= bus.din;
        end else if (wr_back) begin
            mem[i_top] <= bus.pe_fft_a;
            mem[i_bot] <= bus.pe_fft_b;
        end
    end

    // Frame counters: sample count, stage/butterfly position, output index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= 4'd0;
            stage <= 2'd0;
            bfly  <= 3'd0;
            kcnt  <= 4'd0;
        end else begin
            if (take_sample) begin
                wcnt <= wcnt + 4'd1;
            end
            if (frame_full) begin
                stage <= 2'd0;
                bfly  <= 3'd0;
            end
            if (gap_exit) begin
                if (last_bfly) begin
                    kcnt <= 4'd0;
                end else begin
                    bfly <= bfly + 3'd1;
                    if (bfly == 3'd7) begin
                        stage <= stage + 2'd1;
                    end
                end
            end
            if (state == S_OUT) begin
                kcnt <= kcnt + 4'd1;
            end
        end
    end

    // Registered outputs; PE operands and dout hold between updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy        <= 1'b0;
            bus.pe_a        <= 32'd0;
            bus.pe_b        <= 32'd0;
            bus.pe_power    <= 3'd0;
            bus.pe_ab_valid <= 1'b0;
            bus.dout_valid  <= 1'b0;
            bus.dout        <= 32'd0;
            bus.done        <= 1'b0;
        end else begin
            if (bus.done) begin
                bus.busy <= 1'b0;
            end
            if (frame_full) begin
                bus.busy <= 1'b1;
            end
            bus.pe_ab_valid <= (state == S_ISSUE);
            if (state == S_ISSUE) begin
                bus.pe_a     <= mem[i_top];
                bus.pe_b     <= mem[i_bot];
                bus.pe_power <= power;
            end
            if (state == S_OUT) begin
                bus.dout_valid <= 1'b1;
                bus.dout       <= mem[k_rev];
                bus.done       <= (kcnt == 4'd15);
            end else begin
                bus.dout_valid <= 1'b0;
                bus.done       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: table vectors, directed sequences and random
// frames compared against a textbook DIF FFT model built on a behavioural PE.
module tb_fft_ctrl;

    typedef logic [31:0] frame_t [16];

    typedef struct {
        logic [31:0] x0;
        logic [31:0] xr;
        int          lat;
        int          hold;
        int          gap;
        bit          junk;
        logic [31:0] e0;
        logic [31:0] er;
    } vec_t;

    logic clk;
    logic rst;

    fft_ctrl_if bus ();

    fft_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pe_lat = 2;
    int pe_hold = 1;
    int spur_until = 0;

    logic [31:0] out_q [$];
    int          out_cyc [$];
    int          done_q [$];
    logic [31:0] iss_a [$];
    logic [31:0] iss_b [$];
    logic [2:0]  iss_p [$];
    int          iss_cyc [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural PE: a+b and (a-b)*W16^p, Q8.8, 16-bit wrap
    function automatic logic [63:0] pe_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] p);
        int cos_q [8];
        int sin_q [8];
        int ar, ai, br, bi, dr, di, wr, wi, pr, pq;
        logic [15:0] sr, si;
        cos_q = '{256, 237, 181, 98, 0, -98, -181, -237};
        sin_q = '{0, 98, 181, 237, 256, 237, 181, 98};
        ar = int'($signed(a[31:16]));
        ai = int'($signed(a[15:0]));
        br = int'($signed(b[31:16]));
        bi = int'($signed(b[15:0]));
        sr = a[31:16] + b[31:16];
        si = a[15:0] + b[15:0];
        dr = ar - br;
        di = ai - bi;
        wr = cos_q[p];
        wi = -sin_q[p];
        pr = (dr * wr - di * wi) >>> 8;
        pq = (dr * wi + di * wr) >>> 8;
        return {sr, si, pr[15:0], pq[15:0]};
    endfunction

    // Reference: textbook in-place DIF loops, then bit-reversed read-out
    task automatic fft_ref(input frame_t x, output frame_t y);
        frame_t a;
        logic [63:0] r;
        int half;
        int rv;
        a = x;
        for (int st = 0; st < 4; st++) begin
            half = 8 >> st;
            for (int base = 0; base < 16; base += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    r = pe_calc(a[base + j], a[base + j + half], 3'(j << st));
                    a[base + j]        = r[63:32];
                    a[base + j + half] = r[31:0];
                end
            end
        end
        for (int f = 0; f < 16; f++) begin
            rv = 0;
            for (int bt = 0; bt < 4; bt++) if ((f & (1 << bt)) != 0) rv |= (8 >> bt);
            y[f] = a[rv];
        end
    endtask

    // PE model with programmable latency/hold; also injects spurious valids on request
    initial begin : pe_model
        logic [63:0] r;
        bus.pe_fft_valid = 1'b0;
        bus.pe_fft_a = 32'd0;
        bus.pe_fft_b = 32'd0;
        forever begin
            @(negedge clk);
            if (cyc < spur_until) begin
                bus.pe_fft_valid = 1'b1;
                bus.pe_fft_a = $urandom;
                bus.pe_fft_b = $urandom;
            end else if (bus.pe_ab_valid === 1'b1) begin
                r = pe_calc(bus.pe_a, bus.pe_b, bus.pe_power);
                bus.pe_fft_valid = 1'b0;
                if (pe_lat > 1) repeat (pe_lat - 1) @(negedge clk);
                bus.pe_fft_a = r[63:32];
                bus.pe_fft_b = r[31:0];
                bus.pe_fft_valid = 1'b1;
                repeat (pe_hold) @(negedge clk);
                bus.pe_fft_valid = 1'b0;
            end else begin
                bus.pe_fft_valid = 1'b0;
            end
        end
    end

    // Output and issue monitor
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            out_q.push_back(bus.dout);
            out_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_q.push_back(out_q.size());
        if (bus.pe_ab_valid === 1'b1) begin
            iss_a.push_back(bus.pe_a);
            iss_b.push_back(bus.pe_b);
            iss_p.push_back(bus.pe_power);
            iss_cyc.push_back(cyc);
        end
    end

    // Drives 16 samples from a negedge, with optional idle cycles between them
    task automatic load_frame(input frame_t x, input int gap, input bit junk);
        for (int m = 0; m < 16; m++) begin
            if (m == 15) chk("busy_before_last", {31'd0, bus.busy}, 32'd0);
            if (junk && m == 10) spur_until = cyc + 3;
            bus.din_valid = 1'b1;
            bus.din = x[m];
            @(negedge clk);
            if (m == 15) chk("busy_after_last", {31'd0, bus.busy}, 32'd1);
            if (gap > 0) begin
                bus.din_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        bus.din_valid = 1'b0;
        bus.din = 32'd0;
    endtask

    task automatic run_frame(input frame_t x, input int lat, input int hold, input int gap,
                             input bit junk, input frame_t exp, input string tag);
        int ob, db, pb, t;
        pe_lat = lat;
        pe_hold = hold;
        ob = out_q.size();
        db = done_q.size();
        pb = iss_a.size();
        if (junk) begin
            spur_until = cyc + 4;
            repeat (6) @(negedge clk);
        end
        load_frame(x, gap, junk);
        if (junk) begin
            for (int q = 0; q < 20; q++) begin
                bus.din_valid = 1'b1;
                bus.din = $urandom;
                @(negedge clk);
                bus.din_valid = 1'b0;
                @(negedge clk);
            end
        end
        t = 0;
        while (bus.done !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (bus.done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_done_timeout: got no done, expected done within 3000 cycles", tag);
        end
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_busy_after_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_dout_hold"}, bus.dout, exp[15]);
        @(negedge clk);
        chk({tag, "_n_out"}, out_q.size() - ob, 32'd16);
        chk({tag, "_n_issue"}, iss_a.size() - pb, 32'd32);
        chk({tag, "_n_done"}, done_q.size() - db, 32'd1);
        if (done_q.size() > db) chk({tag, "_done_pos"}, done_q[db] - ob, 32'd16);
        if (out_q.size() >= ob + 16) begin
            chk({tag, "_out_span"}, out_cyc[ob + 15] - out_cyc[ob], 32'd15);
            for (int f = 0; f < 16; f++)
                chk($sformatf("%s_bin%0d", tag, f), out_q[ob + f], exp[f]);
        end
    endtask

    initial begin : main
        vec_t   vecs [7];
        frame_t x;
        frame_t e;
        int     ib, ob, cnt, t;
        logic [31:0] ea [6];
        logic [31:0] eb [6];
        logic [2:0]  ep [6];
        int          ei [6];

        rst = 1'b1;
        bus.din_valid = 1'b0;
        bus.din = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_pe_a", bus.pe_a, 32'd0);
        chk("rst_pe_b", bus.pe_b, 32'd0);
        chk("rst_pe_power", {29'd0, bus.pe_power}, 32'd0);
        chk("rst_pe_ab_valid", {31'd0, bus.pe_ab_valid}, 32'd0);
        chk("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Issue order and timing with x[m] = m in the real part, 2-cycle PE
        for (int m = 0; m < 16; m++) x[m] = 32'(m) << 16;
        fft_ref(x, e);
        ib = iss_a.size();
        ob = out_q.size();
        run_frame(x, 2, 1, 0, 1'b0, e, "ramp");
        ei = '{0, 1, 2, 8, 9, 24};
        ea = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0008_0000, 32'h000A_0000, 32'h0038_0000};
        eb = '{32'h0008_0000, 32'h0009_0000, 32'h000A_0000, 32'h0010_0000, 32'h0012_0000, 32'h0040_0000};
        ep = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd2, 3'd0};
        if (iss_a.size() >= ib + 32 && out_q.size() > ob) begin
            for (int q = 0; q < 6; q++) begin
                chk($sformatf("issue%0d_a", ei[q]), iss_a[ib + ei[q]], ea[q]);
                chk($sformatf("issue%0d_b", ei[q]), iss_b[ib + ei[q]], eb[q]);
                chk($sformatf("issue%0d_power", ei[q]), {29'd0, iss_p[ib + ei[q]]}, {29'd0, ep[q]});
            end
            chk("issue_span_cycles", iss_cyc[ib + 31] - iss_cyc[ib], 32'd124);
            chk("first_dout_latency", out_cyc[ob] - iss_cyc[ib + 31], 32'd4);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL ramp_logs: got %0d issues, expected 32 and some outputs", iss_a.size() - ib);
        end

        // Table: {x0, other samples, PE latency, PE hold, input gap, junk, bin0, other bins}
        vecs[0] = '{x0: 32'h0100_0000, xr: 32'h0, lat: 2, hold: 1, gap: 0, junk: 1'b0,
                    e0: 32'h0100_0000, er: 32'h0100_0000};
        vecs[1] = '{x0: 32'h0100_0000, xr: 32'h0100_0000, lat: 2, hold: 1, gap: 0, junk: 1'b0,
                    e0: 32'h1000_0000, er: 32'h0};
        vecs[2] = '{x0: 32'h0100_0000, xr: 32'h0100_0000, lat: 2, hold: 3, gap: 1, junk: 1'b1,
                    e0: 32'h1000_0000, er: 32'h0};
        vecs[3] = '{x0: 32'hFF00_FF00, xr: 32'hFF00_FF00, lat: 1, hold: 1, gap: 0, junk: 1'b0,
                    e0: 32'hF000_F000, er: 32'h0};
        vecs[4] = '{x0: 32'h0100_0000, xr: 32'h0, lat: 4, hold: 2, gap: 2, junk: 1'b1,
                    e0: 32'h0100_0000, er: 32'h0100_0000};
        vecs[5] = '{x0: 32'h0, xr: 32'h0, lat: 3, hold: 1, gap: 0, junk: 1'b0,
                    e0: 32'h0, er: 32'h0};
        vecs[6] = '{x0: 32'h0000_0100, xr: 32'h0000_0100, lat: 1, hold: 2, gap: 1, junk: 1'b0,
                    e0: 32'h0000_1000, er: 32'h0};
        for (int v = 0; v < 7; v++) begin
            for (int m = 0; m < 16; m++) begin
                x[m] = (m == 0) ? vecs[v].x0 : vecs[v].xr;
                e[m] = (m == 0) ? vecs[v].e0 : vecs[v].er;
            end
            run_frame(x, vecs[v].lat, vecs[v].hold, vecs[v].gap, vecs[v].junk, e,
                      $sformatf("vec%0d", v));
        end

        // Random frames against the reference model
        for (int r = 0; r < 4; r++) begin
            for (int m = 0; m < 16; m++) x[m] = $urandom;
            fft_ref(x, e);
            run_frame(x, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), e,
                      $sformatf("rand%0d", r));
        end

        // Reset after 20 butterflies, then a fresh impulse frame
        pe_lat = 2;
        pe_hold = 1;
        for (int m = 0; m < 16; m++) x[m] = $urandom | 32'h0001_0001;
        load_frame(x, 0, 1'b0);
        cnt = 0;
        t = 0;
        while (cnt < 20 && t < 2000) begin
            @(negedge clk);
            t++;
            if (bus.pe_ab_valid === 1'b1) cnt++;
        end
        if (cnt < 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL midrst_wait: got %0d issues, expected 20", cnt);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_pe_a", bus.pe_a, 32'd0);
        chk("midrst_pe_b", bus.pe_b, 32'd0);
        chk("midrst_pe_power", {29'd0, bus.pe_power}, 32'd0);
        chk("midrst_pe_ab_valid", {31'd0, bus.pe_ab_valid}, 32'd0);
        chk("midrst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("midrst_dout", bus.dout, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int m = 0; m < 16; m++) begin
            x[m] = (m == 0) ? 32'h0100_0000 : 32'h0;
            e[m] = 32'h0100_0000;
        end
        run_frame(x, 2, 1, 0, 1'b0, e, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
